sram_like_arbiter: RTL and testbench

Two-master to one-slave arbiter for the sram-like bus. It merges the CPU instruction channel (master 0) and data channel (master 1) onto a single sram-like slave port that feeds the shared AXI bridge. It tracks in-order outstanding transactions in an ID FIFO and routes each data_ok/rdata response back to the master that issued it.

---
 rtl/sram_like_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave sram-like arbiter with in-order response routing.
// Data master wins arbitration; a stalled handshake locks the grant.
module sram_like_arbiter #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             m0_req,
   input  logic             m0_wr,
   input  logic [1:0]       m0_size,
   input  logic [31:0]      m0_addr,
   input  logic [31:0]      m0_wdata,
   output logic [31:0]      m0_rdata,
   output logic             m0_addr_ok,
   output logic             m0_data_ok,
   input  logic             m1_req,
   input  logic             m1_wr,
   input  logic [1:0]       m1_size,
   input  logic [31:0]      m1_addr,
   input  logic [31:0]      m1_wdata,
   output logic [31:0]      m1_rdata,
   output logic             m1_addr_ok,
   output logic             m1_data_ok,
   output logic             s_req,
   output logic             s_wr,
   output logic [1:0]       s_size,
   output logic [31:0]      s_addr,
   output logic [31:0]      s_wdata,
   input  logic [31:0]      s_rdata,
   input  logic             s_addr_ok,
   input  logic             s_data_ok,
   output logic [CNT_W-1:0] outstanding,
   output logic             err_stray
);

   localparam int AW = $clog2(DEPTH);

   logic          lock;
   logic          lock_id;
   logic          gnt_vld;
   logic          gnt_id;
   logic          g_req;
   logic          full;
   logic          nonempty;
   logic          accept;
   logic          pop;
   logic          head;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          fifo [DEPTH];

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (lock) begin
         gnt_vld = 1'b1;
         gnt_id  = lock_id;
      end else if (m1_req) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b1;
      end else if (m0_req) begin
         gnt_vld = 1'b1;
      end
   end

   assign full  = (outstanding == CNT_W'(DEPTH));
   assign g_req = gnt_vld & (gnt_id ? m1_req : m0_req);
   assign s_req = g_req & ~full;

   always_comb begin
      s_wr    = 1'b0;
      s_size  = 2'd0;
      s_addr  = 32'd0;
      s_wdata = 32'd0;
      if (gnt_vld) begin
         s_wr    = gnt_id ? m1_wr    : m0_wr;
         s_size  = gnt_id ? m1_size  : m0_size;
         s_addr  = gnt_id ? m1_addr  : m0_addr;
         s_wdata = gnt_id ? m1_wdata : m0_wdata;
      end
   end

   assign accept     = s_req & s_addr_ok;
   assign m0_addr_ok = accept & ~gnt_id;
   assign m1_addr_ok = accept & gnt_id;

   assign nonempty   = (outstanding != '0);
   assign pop        = s_data_ok & nonempty;
   assign head       = fifo[rd_ptr];
   assign m0_data_ok = pop & ~head;
   assign m1_data_ok = pop & head;
   assign m0_rdata   = s_rdata;
   assign m1_rdata   = s_rdata;

   // ID storage needs no reset: entries are only read while occupied
   always_ff @(posedge clk) begin
      if (accept) fifo[wr_ptr] <= gnt_id;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         outstanding <= '0;
         lock        <= 1'b0;
         lock_id     <= 1'b0;
         err_stray   <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         if (accept & ~pop)
            outstanding <= outstanding + CNT_W'(1);
         else if (pop & ~accept)
            outstanding <= outstanding - CNT_W'(1);
         if (s_data_ok & ~nonempty) err_stray <= 1'b1;
         if (accept) begin
            lock <= 1'b0;
         end else if (s_req & ~s_addr_ok) begin
            lock    <= 1'b1;
            lock_id <= gnt_id;
         end else if (lock & ~g_req) begin
            lock <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed plan sequences, then random
// traffic, all checked against a queue-based model every cycle.
module tb_sram_like_arbiter;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
   logic [1:0] m0_size = 0, m1_size = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic [31:0] s_rdata = 0;
   logic s_addr_ok = 0, s_data_ok = 0;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
   logic m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
   logic s_req, s_wr, err_stray;
   logic [1:0] s_size;
   logic [CNT_W-1:0] outstanding;

   sram_like_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
      .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
      .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
      .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_rdata(s_rdata), .s_addr_ok(s_addr_ok),
      .s_data_ok(s_data_ok), .outstanding(outstanding),
      .err_stray(err_stray)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: ids of accepted-but-unanswered transactions in order, plus the
   // master whose request the slave has seen but not yet taken (-1: none).
   int  q[$];
   int  held = -1;
   bit  m_err = 0;
   bit  mvalid = 0;

   always @(negedge clk) begin
      int  g;
      bit  greq, full, acc, ne;
      logic [31:0] ea, ew;
      logic [1:0] es;
      logic ewr;
      if (!resetn) begin
         q.delete();
         held = -1;
         m_err = 0;
         mvalid = 1;
      end else if (mvalid) begin
         if (held >= 0) g = held;
         else if (m1_req) g = 1;
         else if (m0_req) g = 0;
         else g = -1;
         greq = (g == 1) ? m1_req : (g == 0) ? m0_req : 1'b0;
         full = (q.size() == DEPTH);
         ewr = 0; es = 0; ea = 0; ew = 0;
         if (g == 1) begin ewr = m1_wr; es = m1_size; ea = m1_addr; ew = m1_wdata; end
         if (g == 0) begin ewr = m0_wr; es = m0_size; ea = m0_addr; ew = m0_wdata; end
         acc = greq && !full && s_addr_ok;
         ne = (q.size() != 0);
         chk("s_req", s_req, greq && !full);
         chk("s_wr", s_wr, ewr);
         chk("s_size", s_size, es);
         chk("s_addr", s_addr, ea);
         chk("s_wdata", s_wdata, ew);
         chk("m0_addr_ok", m0_addr_ok, acc && g == 0);
         chk("m1_addr_ok", m1_addr_ok, acc && g == 1);
         chk("m0_data_ok", m0_data_ok, s_data_ok && ne && q[0] == 0);
         chk("m1_data_ok", m1_data_ok, s_data_ok && ne && q[0] == 1);
         chk("m0_rdata", m0_rdata, s_rdata);
         chk("m1_rdata", m1_rdata, s_rdata);
         chk("outstanding", outstanding, q.size());
         chk("err_stray", err_stray, m_err);
         if (s_data_ok && ne) void'(q.pop_front());
         if (s_data_ok && !ne) m_err = 1;
         if (acc) q.push_back(g);
         if (acc) held = -1;
         else if (greq && !full && !s_addr_ok) held = g;
         else if (held >= 0 && !greq) held = -1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      resetn = 1;
      @(negedge clk);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_s_req", s_req, 0);
      chk("rst_err", err_stray, 0);

      // inst read with two-cycle response
      tick();
      m0_req = 1; m0_addr = 32'hBFC00000; s_addr_ok = 1;
      @(negedge clk);
      chk("t1_s_addr", s_addr, 32'hBFC00000);
      chk("t1_addr_ok", m0_addr_ok, 1);
      tick();
      m0_req = 0; s_addr_ok = 0;
      @(negedge clk);
      chk("t1_out1", outstanding, 1);
      chk("t1_addr_ok_low", m0_addr_ok, 0);
      tick();
      tick();
      s_data_ok = 1; s_rdata = 32'h3C1D0000;
      @(negedge clk);
      chk("t1_m0_dok", m0_data_ok, 1);
      chk("t1_m1_dok", m1_data_ok, 0);
      chk("t1_rdata", m0_rdata, 32'h3C1D0000);
      tick();
      s_data_ok = 0;
      @(negedge clk);
      chk("t1_out0", outstanding, 0);

      // both masters request, data wins
      tick();
      m0_req = 1; m0_addr = 32'hBFC00004;
      m1_req = 1; m1_addr = 32'h80001000; s_addr_ok = 1;
      @(negedge clk);
      chk("t2_m1_first", m1_addr_ok, 1);
      chk("t2_addr1", s_addr, 32'h80001000);
      tick();
      m1_req = 0;
      @(negedge clk);
      chk("t2_m0_second", m0_addr_ok, 1);
      tick();
      m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
      @(negedge clk);
      chk("t2_resp1_m1", m1_data_ok, 1);
      tick();
      @(negedge clk);
      chk("t2_resp2_m0", m0_data_ok, 1);
      tick();
      s_data_ok = 0;

      // stalled m0 holds the bus against a later m1 request
      m0_req = 1; m0_addr = 32'hBFC00010;
      @(negedge clk);
      chk("t3_c1", s_addr, 32'hBFC00010);
      tick();
      m1_req = 1; m1_addr = 32'h80002000;
      @(negedge clk);
      chk("t3_c2", s_addr, 32'hBFC00010);
      tick();
      @(negedge clk);
      chk("t3_c3", s_addr, 32'hBFC00010);
      tick();
      s_addr_ok = 1;
      @(negedge clk);
      chk("t3_m0_acc", m0_addr_ok, 1);
      tick();
      m0_req = 0;
      @(negedge clk);
      chk("t3_m1_acc", m1_addr_ok, 1);
      tick();
      m1_req = 0; s_addr_ok = 0; s_data_ok = 1;
      tick();
      tick();
      s_data_ok = 0;

      // fill to DEPTH, then a fifth request waits for a pop
      m0_req = 1; s_addr_ok = 1;
      for (int i = 0; i < DEPTH; i++) begin
         m0_addr = 32'h1000 + 32'(i * 4);
         tick();
      end
      m0_addr = 32'h2000;
      @(negedge clk);
      chk("t4_full_cnt", outstanding, DEPTH);
      chk("t4_full_sreq", s_req, 0);
      tick();
      s_data_ok = 1;
      @(negedge clk);
      chk("t4_pop_sreq", s_req, 0);
      tick();
      s_data_ok = 0;
      @(negedge clk);
      chk("t4_reissue", s_req, 1);
      chk("t4_fifth_acc", m0_addr_ok, 1);
      tick();
      m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
      for (int i = 0; i < DEPTH; i++) tick();
      s_data_ok = 0;

      // interleaved ids, twice to cross the pointer wrap
      for (int b = 0; b < 2; b++) begin
         s_addr_ok = 1;
         m0_req = 1; tick();
         m0_req = 0; m1_req = 1; tick();
         tick();
         m1_req = 0; m0_req = 1; tick();
         m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_m0", m0_data_ok, (i == 0 || i == 3));
            chk("t5_m1", m1_data_ok, (i == 1 || i == 2));
            tick();
         end
         s_data_ok = 0;
      end

      // stray response, then reset with two in flight
      s_data_ok = 1;
      tick();
      s_data_ok = 0;
      @(negedge clk);
      chk("t6_stray", err_stray, 1);
      m0_req = 1; s_addr_ok = 1;
      tick();
      tick();
      m0_req = 0; s_addr_ok = 0;
      @(negedge clk);
      chk("t6_sticky", err_stray, 1);
      chk("t6_out2", outstanding, 2);
      resetn = 0;
      tick();
      resetn = 1;
      @(negedge clk);
      chk("t6_rst_out", outstanding, 0);
      chk("t6_rst_err", err_stray, 0);
      chk("t6_rst_sreq", s_req, 0);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         tick();
         resetn    = ($urandom_range(0, 199) != 0);
         m0_req    = ($urandom_range(0, 9) < 6);
         m1_req    = ($urandom_range(0, 9) < 4);
         m0_wr     = $urandom_range(0, 1);
         m1_wr     = $urandom_range(0, 1);
         m0_size   = 2'($urandom_range(0, 3));
         m1_size   = 2'($urandom_range(0, 3));
         m0_addr   = $urandom;
         m1_addr   = $urandom;
         m0_wdata  = $urandom;
         m1_wdata  = $urandom;
         s_addr_ok = $urandom_range(0, 1);
         s_data_ok = ($urandom_range(0, 9) < 4);
         s_rdata   = $urandom;
      end
      tick();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
